// File: rtl/comparator_serial.sv
// comparator_serial: multi-cycle magnitude comparator, DIGIT bits per clock, MSB digit first.
// Ports:
//   clk, rst (async, active-low)
//   start, signed_mode, A, B : compare request and operands, sampled when idle
//   busy, done               : handshake status, done is a one-cycle pulse
//   A_gt_B_reg, A_eq_B_reg, A_lt_B_reg : registered result flags, held until the next done
// Optional: define COMPARATOR_EARLY_EXIT_EN to finish at the first differing digit.
module comparator_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B_reg,
    output logic             A_eq_B_reg,
    output logic             A_lt_B_reg
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {EQ, GT, LT} res_t;
    state_t           state;
    res_t             res, res_nxt;
    logic [WIDTH-1:0] sa, sb, flip;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] da, db;
    logic             fin;
    always_comb begin
        da      = sa[WIDTH-1 -: DIGIT];
        db      = sb[WIDTH-1 -: DIGIT];
        // once a digit differs the verdict is fixed; lower digits cannot change it
        res_nxt = res != EQ ? res : da > db ? GT : da < db ? LT : EQ;
`ifdef COMPARATOR_EARLY_EXIT_EN
        fin     = cnt == CW'(N - 1) || res_nxt != EQ;
`else
        fin     = cnt == CW'(N - 1);
`endif
        // inverting the sign bit maps two's complement onto offset binary
        flip    = {signed_mode, {(WIDTH-1){1'b0}}};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            res        <= EQ;
            sa         <= '0;
            sb         <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            A_gt_B_reg <= 1'b0;
            A_eq_B_reg <= 1'b0;
            A_lt_B_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sa    <= A ^ flip;
                    sb    <= B ^ flip;
                    cnt   <= '0;
                    res   <= EQ;
                    busy  <= 1'b1;
                    state <= RUN;
                end
            end else begin
                sa  <= sa << DIGIT;
                sb  <= sb << DIGIT;
                cnt <= cnt + 1'b1;
                res <= res_nxt;
                if (fin) begin
                    A_gt_B_reg <= res_nxt == GT;
                    A_eq_B_reg <= res_nxt == EQ;
                    A_lt_B_reg <= res_nxt == LT;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            end
        end
    end
endmodule
